// File: rtl/prog_mem_pkg.sv
// ---------------------------------------------------------------------------
// prog_mem_pkg
// Shared definitions for the program-memory loader:
//   - default RAM geometry (ADDR_W_DEF / DATA_W_DEF)
//   - number of cycles spent in RELEASE before the CPU leaves reset
//   - the loader state encoding
// ---------------------------------------------------------------------------
package prog_mem_pkg;

    localparam int ADDR_W_DEF     = 8;
    localparam int DATA_W_DEF     = 16;
    localparam int RELEASE_CYCLES = 2;

    typedef enum logic [2:0] {
        WAIT_CNT = 3'd0,
        RX_HI    = 3'd1,
        RX_LO    = 3'd2,
        RX_CSUM  = 3'd3,
        RELEASE  = 3'd4,
        RUN      = 3'd5,
        ERROR    = 3'd6
    } loadState_t;

endpackage

// File: rtl/prog_mem_loader_sp_ram.sv
// ---------------------------------------------------------------------------
// sp_ram
// Single-port word RAM, 2**ADDR_W x DATA_W.
// Synchronous write, registered read. A read and a write to the same address
// on the same edge return the OLD contents. The array has no reset so its
// contents survive a system reset.
// Ports:
//   i_clk    clock
//   i_we     write enable (sampled at posedge)
//   i_addr   word address
//   i_wdata  write data
//   o_rdata  registered read data, valid one cycle after i_addr
// ---------------------------------------------------------------------------
module sp_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_rdata;

    // The read register samples the array before this edge's write lands,
    // which is what gives read-old-data on a same-address collision.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/prog_mem_loader.sv
// ---------------------------------------------------------------------------
// prog_mem_loader
// Program-memory stage on the CPU RAM bus. After reset it fills the word RAM
// from a UART byte stream framed as  N, {hi, lo} x N, CSUM  (N = 0 means a full
// 2**ADDR_W words; CSUM is the 8-bit wrapping sum of N and all data bytes)
// while holding the CPU in reset. A good checksum releases the CPU, which then
// owns the RAM port. A bad checksum or an inter-byte timeout parks in ERROR.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   rx_data, rx_valid           received byte and its 1-cycle strobe
//   boot_skip                   in WAIT_CNT: skip the load and run existing RAM
//   cpu_address/_data_out/_ram_rw  CPU RAM request (1 = write)
//   cpu_data_in                 registered read data, 0 outside RUN
//   cpu_rst_n                   CPU reset, high only in RUN
//   load_busy                   high in any load state (WAIT_CNT..RELEASE)
//   load_error                  high in ERROR until the next reset
// ---------------------------------------------------------------------------
module prog_mem_loader
    import prog_mem_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 1_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              boot_skip,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic [DATA_W-1:0] cpu_data_out,
    input  logic              cpu_ram_rw,
    output logic [DATA_W-1:0] cpu_data_in,
    output logic              cpu_rst_n,
    output logic              load_busy,
    output logic              load_error
);

    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam int RC_W = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;

    loadState_t        r_state;
    loadState_t        w_stateNext;
    logic [ADDR_W-1:0] r_count;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_sum;
    logic [7:0]        r_hi;
    logic [TO_W-1:0]   r_toCnt;
    logic [RC_W-1:0]   r_relCnt;

    logic              w_timedOut;
    logic              w_lastWord;
    logic              w_ramWe;
    logic [ADDR_W-1:0] w_ramAddr;
    logic [DATA_W-1:0] w_ramWdata;
    logic [DATA_W-1:0] w_ramRdata;
    logic [DATA_W-1:0] w_loadWord;

    assign w_timedOut = (r_toCnt == TO_W'(TIMEOUT - 1));
    // Count of 0 wraps to all-ones here, which makes N=0 end after 2**ADDR_W words.
    assign w_lastWord = (r_addr == (r_count - ADDR_W'(1)));
    assign w_loadWord = DATA_W'({r_hi, rx_data});

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= WAIT_CNT;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state decode. boot_skip wins over a byte arriving in the same cycle.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            WAIT_CNT: begin
                if (boot_skip) begin
                    w_stateNext = RELEASE;
                end else if (rx_valid) begin
                    w_stateNext = RX_HI;
                end
            end
            RX_HI: begin
                if (rx_valid) begin
                    w_stateNext = RX_LO;
                end else if (w_timedOut) begin
                    w_stateNext = ERROR;
                end
            end
            RX_LO: begin
                if (rx_valid) begin
                    w_stateNext = w_lastWord ? RX_CSUM : RX_HI;
                end else if (w_timedOut) begin
                    w_stateNext = ERROR;
                end
            end
            RX_CSUM: begin
                if (rx_valid) begin
                    w_stateNext = (rx_data == r_sum) ? RELEASE : ERROR;
                end else if (w_timedOut) begin
                    w_stateNext = ERROR;
                end
            end
            RELEASE: begin
                if (r_relCnt == '0) begin
                    w_stateNext = RUN;
                end
            end
            RUN:     w_stateNext = RUN;
            ERROR:   w_stateNext = ERROR;
            default: w_stateNext = ERROR;
        endcase
    end

    // Load datapath: frame length, write address, running checksum, held hi
    // byte and the RELEASE countdown (preloaded while waiting for a frame).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count  <= '0;
            r_addr   <= '0;
            r_sum    <= '0;
            r_hi     <= '0;
            r_relCnt <= RC_W'(RELEASE_CYCLES - 1);
        end else begin
            case (r_state)
                WAIT_CNT: begin
                    r_relCnt <= RC_W'(RELEASE_CYCLES - 1);
                    if (!boot_skip && rx_valid) begin
                        r_count <= rx_data[ADDR_W-1:0];
                        r_sum   <= rx_data;
                        r_addr  <= '0;
                    end
                end
                RX_HI: begin
                    if (rx_valid) begin
                        r_hi  <= rx_data;
                        r_sum <= r_sum + rx_data;
                    end
                end
                RX_LO: begin
                    if (rx_valid) begin
                        r_sum  <= r_sum + rx_data;
                        r_addr <= r_addr + ADDR_W'(1);
                    end
                end
                RELEASE: begin
                    if (r_relCnt != '0) begin
                        r_relCnt <= r_relCnt - RC_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Inter-byte timeout: only runs once a frame has started, restarts on
    // every received byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_toCnt <= '0;
        end else if ((r_state == RX_HI) || (r_state == RX_LO) || (r_state == RX_CSUM)) begin
            r_toCnt <= rx_valid ? '0 : (r_toCnt + TO_W'(1));
        end else begin
            r_toCnt <= '0;
        end
    end

    // RAM port mux. The CPU address is already routed in RELEASE so the very
    // first RUN cycle presents data for the address the CPU is driving.
    always_comb begin
        w_ramWe    = 1'b0;
        w_ramAddr  = r_addr;
        w_ramWdata = w_loadWord;
        if (r_state == RUN) begin
            w_ramWe    = cpu_ram_rw;
            w_ramAddr  = cpu_address;
            w_ramWdata = cpu_data_out;
        end else if (r_state == RELEASE) begin
            w_ramAddr = cpu_address;
        end else if ((r_state == RX_LO) && rx_valid) begin
            w_ramWe = 1'b1;
        end
    end

    sp_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .i_clk   (clk),
        .i_we    (w_ramWe),
        .i_addr  (w_ramAddr),
        .i_wdata (w_ramWdata),
        .o_rdata (w_ramRdata)
    );

    assign cpu_data_in = (r_state == RUN) ? w_ramRdata : '0;
    assign cpu_rst_n   = (r_state == RUN);
    assign load_busy   = (r_state == WAIT_CNT) || (r_state == RX_HI) || (r_state == RX_LO) ||
                         (r_state == RX_CSUM) || (r_state == RELEASE);
    assign load_error  = (r_state == ERROR);

endmodule

// File: tb/tb_prog_mem_loader.sv
// ---------------------------------------------------------------------------
// tb_prog_mem_loader
// Self-checking bench for prog_mem_loader (TIMEOUT shortened to 100).
// Keeps a word-array model of the RAM, updated whenever a frame word or a CPU
// write is sent, and compares CPU reads and control outputs against it.
// ---------------------------------------------------------------------------
module tb_prog_mem_loader;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 16;
    localparam int TIMEOUT = 100;
    localparam int DEPTH   = 2**ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [7:0]        rx_data = '0;
    logic              rx_valid = 1'b0;
    logic              boot_skip = 1'b0;
    logic [ADDR_W-1:0] cpu_address = '0;
    logic [DATA_W-1:0] cpu_data_out = '0;
    logic              cpu_ram_rw = 1'b0;
    logic [DATA_W-1:0] cpu_data_in;
    logic              cpu_rst_n;
    logic              load_busy;
    logic              load_error;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] refMem [DEPTH];
    bit          refKnown [DEPTH];
    logic [15:0] frameWords [DEPTH];

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic [15:0] expRd;
    } cpuVec_t;

    cpuVec_t cpuTable [9];

    always #5 clk = ~clk;

    prog_mem_loader #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .boot_skip    (boot_skip),
        .cpu_address  (cpu_address),
        .cpu_data_out (cpu_data_out),
        .cpu_ram_rw   (cpu_ram_rw),
        .cpu_data_in  (cpu_data_in),
        .cpu_rst_n    (cpu_rst_n),
        .load_busy    (load_busy),
        .load_error   (load_error)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Every task starts and ends 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] b, input int gap);
        repeat (gap) tick();
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    // Assert reset, check the reset-value outputs straight away, then release.
    task automatic doReset(input logic skip, input string tag);
        rst_n = 1'b0;
        #1;
        checkOutput({tag, " rst cpu_rst_n"}, 32'(cpu_rst_n), 0);
        checkOutput({tag, " rst load_busy"}, 32'(load_busy), 1);
        checkOutput({tag, " rst load_error"}, 32'(load_error), 0);
        checkOutput({tag, " rst cpu_data_in"}, 32'(cpu_data_in), 0);
        tick();
        tick();
        boot_skip = skip;
        rst_n     = 1'b1;
    endtask

    task automatic sendFrame(input int n, input logic bad, input int maxGap);
        int         cnt;
        logic [7:0] sum;
        cnt = (n == 0) ? DEPTH : n;
        sum = 8'(n);
        applyStimulus(8'(n), int'($urandom_range(0, maxGap)));
        checkOutput("loading cpu_rst_n", 32'(cpu_rst_n), 0);
        checkOutput("loading load_busy", 32'(load_busy), 1);
        for (int i = 0; i < cnt; i++) begin
            applyStimulus(frameWords[i][15:8], int'($urandom_range(0, maxGap)));
            sum += frameWords[i][15:8];
            applyStimulus(frameWords[i][7:0], int'($urandom_range(0, maxGap)));
            sum += frameWords[i][7:0];
            refMem[i]   = frameWords[i];
            refKnown[i] = 1'b1;
        end
        applyStimulus(bad ? (sum + 8'd1) : sum, int'($urandom_range(0, maxGap)));
    endtask

    // Called right after the checksum byte's edge.
    task automatic expectLoadEnd(input logic bad, input string tag);
        if (bad) begin
            checkOutput({tag, " err load_error"}, 32'(load_error), 1);
            checkOutput({tag, " err cpu_rst_n"}, 32'(cpu_rst_n), 0);
            checkOutput({tag, " err load_busy"}, 32'(load_busy), 0);
            applyStimulus(8'h00, 2);
            tick();
            checkOutput({tag, " err sticky"}, 32'(load_error), 1);
            checkOutput({tag, " err cpu_rst_n held"}, 32'(cpu_rst_n), 0);
            checkOutput({tag, " err cpu_data_in"}, 32'(cpu_data_in), 0);
        end else begin
            checkOutput({tag, " rel0 cpu_rst_n"}, 32'(cpu_rst_n), 0);
            checkOutput({tag, " rel0 load_busy"}, 32'(load_busy), 1);
            tick();
            checkOutput({tag, " rel1 cpu_rst_n"}, 32'(cpu_rst_n), 0);
            tick();
            checkOutput({tag, " run cpu_rst_n"}, 32'(cpu_rst_n), 1);
            checkOutput({tag, " run load_busy"}, 32'(load_busy), 0);
            checkOutput({tag, " run load_error"}, 32'(load_error), 0);
        end
    endtask

    // One CPU cycle; read data is compared against the model's contents before
    // this cycle's write, and a stray rx byte may be thrown in to be ignored.
    task automatic cpuOp(input logic wr, input logic [7:0] a, input logic [15:0] d, input string name);
        logic [15:0] expData;
        bit          known;
        expData      = refMem[a];
        known        = refKnown[a];
        cpu_address  = a;
        cpu_ram_rw   = wr;
        cpu_data_out = d;
        rx_valid     = 1'($urandom_range(0, 1));
        rx_data      = 8'($urandom);
        tick();
        cpu_ram_rw = 1'b0;
        rx_valid   = 1'b0;
        if (known) begin
            checkOutput(name, 32'(cpu_data_in), 32'(expData));
        end
        if (wr) begin
            refMem[a]   = d;
            refKnown[a] = 1'b1;
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            refKnown[i] = 1'b0;
        end

        cpuTable[0] = '{1'b0, 8'h00, 16'h0000, 16'h1234};
        cpuTable[1] = '{1'b0, 8'h01, 16'h0000, 16'hABCD};
        cpuTable[2] = '{1'b1, 8'h10, 16'h5555, 16'h0010};
        cpuTable[3] = '{1'b0, 8'h10, 16'h0000, 16'h5555};
        cpuTable[4] = '{1'b1, 8'h10, 16'hAAAA, 16'h5555};
        cpuTable[5] = '{1'b0, 8'h10, 16'h0000, 16'hAAAA};
        cpuTable[6] = '{1'b1, 8'h00, 16'h0F0F, 16'h1234};
        cpuTable[7] = '{1'b0, 8'h00, 16'h0000, 16'h0F0F};
        cpuTable[8] = '{1'b0, 8'hFF, 16'h0000, 16'h00FF};

        tick();

        // Full-depth load (N=0), address as data.
        doReset(1'b0, "full");
        for (int i = 0; i < DEPTH; i++) begin
            frameWords[i] = 16'(i);
        end
        sendFrame(0, 1'b0, 0);
        expectLoadEnd(1'b0, "full");
        cpuOp(1'b0, 8'hFF, 16'h0, "full rd ff");
        cpuOp(1'b0, 8'h80, 16'h0, "full rd 80");

        // Two-word frame, good checksum, then table-driven CPU traffic.
        doReset(1'b0, "two");
        frameWords[0] = 16'h1234;
        frameWords[1] = 16'hABCD;
        sendFrame(2, 1'b0, 2);
        expectLoadEnd(1'b0, "two");
        for (int i = 0; i < 9; i++) begin
            cpu_address  = cpuTable[i].addr;
            cpu_ram_rw   = cpuTable[i].wr;
            cpu_data_out = cpuTable[i].wdata;
            tick();
            cpu_ram_rw = 1'b0;
            checkOutput($sformatf("table %0d", i), 32'(cpu_data_in), 32'(cpuTable[i].expRd));
            if (cpuTable[i].wr) begin
                refMem[cpuTable[i].addr]   = cpuTable[i].wdata;
                refKnown[cpuTable[i].addr] = 1'b1;
            end
        end

        // Same frame with a wrong checksum.
        doReset(1'b0, "bad");
        sendFrame(2, 1'b1, 1);
        expectLoadEnd(1'b1, "bad");

        // Stall after the hi byte of word 1: timeout lands exactly 100 cycles later.
        doReset(1'b0, "tmo");
        applyStimulus(8'd2, 0);
        applyStimulus(8'h13, 0);
        applyStimulus(8'h57, 0);
        refMem[0]   = 16'h1357;
        refKnown[0] = 1'b1;
        applyStimulus(8'h99, 0);
        repeat (TIMEOUT - 1) tick();
        checkOutput("tmo before", 32'(load_error), 0);
        checkOutput("tmo before busy", 32'(load_busy), 1);
        tick();
        checkOutput("tmo at", 32'(load_error), 1);
        checkOutput("tmo cpu_rst_n", 32'(cpu_rst_n), 0);
        doReset(1'b1, "tmoskip");
        tick();
        tick();
        checkOutput("tmoskip pre-run", 32'(cpu_rst_n), 0);
        tick();
        checkOutput("tmoskip run", 32'(cpu_rst_n), 1);
        boot_skip = 1'b0;
        cpuOp(1'b0, 8'h00, 16'h0, "tmo mem0 kept");
        cpuOp(1'b0, 8'h01, 16'h0, "tmo mem1 kept");

        // Reset in the middle of RX_LO, then boot straight from existing RAM.
        doReset(1'b0, "abort");
        applyStimulus(8'd3, 0);
        applyStimulus(8'h24, 0);
        applyStimulus(8'h68, 0);
        refMem[0] = 16'h2468;
        applyStimulus(8'h77, 0);
        doReset(1'b1, "abort");
        tick();
        checkOutput("abort skip c1", 32'(cpu_rst_n), 0);
        tick();
        checkOutput("abort skip c2", 32'(cpu_rst_n), 0);
        tick();
        checkOutput("abort skip c3", 32'(cpu_rst_n), 1);
        boot_skip = 1'b0;
        for (int a = 0; a < 3; a++) begin
            cpuOp(1'b0, 8'(a), 16'h0, $sformatf("abort mem%0d", a));
        end

        // Random frames and random CPU traffic against the model.
        for (int r = 0; r < 6; r++) begin
            int   n;
            logic bad;
            n   = int'($urandom_range(1, 12));
            bad = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < n; i++) begin
                frameWords[i] = 16'($urandom);
            end
            doReset(1'b0, $sformatf("rnd%0d", r));
            sendFrame(n, bad, 4);
            expectLoadEnd(bad, $sformatf("rnd%0d", r));
            if (!bad) begin
                for (int k = 0; k < 20; k++) begin
                    cpuOp(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 16'($urandom),
                          $sformatf("rnd%0d op%0d", r, k));
                end
                checkOutput($sformatf("rnd%0d still run", r), 32'(cpu_rst_n), 1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
